// File: rtl/hazard_pkg.sv
// Shared types for the RV32 pipeline hazard controller: multi-cycle FSM state,
// pipeline-register control bundle and a register-match helper.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
        logic flush_wb;
    } pipe_ctrl_t;

    function automatic logic reg_match(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/mc_sequencer.sv
// Multi-cycle EX operation sequencer: start pulse, wait for done, abort on timeout.
// Counter saturates so a long dmem wait inside MC_BUSY cannot wrap it past the limit.
module mc_sequencer
    import hazard_pkg::*;
#(
    parameter int MC_TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ex_mc_op_i,
    input  logic mc_done_i,
    input  logic mem_stall_i,
    output logic mc_start_o,
    output logic mc_timeout_o,
    output logic mc_stall_o,
    output logic mc_active_o
);

    localparam int CW = $clog2(MC_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MC_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    mc_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mc_start_o   = 1'b0;
        mc_timeout_o = 1'b0;
        mc_stall_o   = 1'b0;
        mc_active_o  = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_mc_op_i) begin
                    mc_active_o = 1'b1;
                    if (!mem_stall_i) begin
                        mc_start_o = 1'b1;
                        mc_stall_o = 1'b1;
                        state_d    = MC_BUSY;
                        cnt_d      = CW'(1);
                    end
                end
            end
            MC_BUSY: begin
                mc_active_o = 1'b1;
                if (mem_stall_i) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                end else if (mc_done_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    mc_timeout_o = 1'b1;
                    state_d      = RUN;
                    cnt_d        = '0;
                end else begin
                    mc_stall_o = 1'b1;
                    cnt_d      = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush generator for the 5-stage RV32 core. Priority:
// dmem wait > multi-cycle op > redirect > load-use. Outputs forced low during reset.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_reg_write_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_mc_op_i,
    input  logic             ex_branch_taken_i,
    input  logic             mc_done_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_mem_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             flush_mem_o,
    output logic             flush_wb_o,
    output logic             mc_start_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic       mem_stall, load_use;
    logic       seq_start, seq_timeout, seq_stall, seq_active;
    pipe_ctrl_t ctrl;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign mem_stall = mem_req_i & ~mem_ready_i;
    assign load_use  = ex_mem_read_i & ex_reg_write_i & (ex_rd_i != REG_ZERO) &
                       (reg_match(id_uses_rs1_i, id_rs1_i, ex_rd_i) |
                        reg_match(id_uses_rs2_i, id_rs2_i, ex_rd_i));

    mc_sequencer #(
        .MC_TIMEOUT (MC_TIMEOUT)
    ) u_mc_seq (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ex_mc_op_i   (ex_mc_op_i),
        .mc_done_i    (mc_done_i),
        .mem_stall_i  (mem_stall),
        .mc_start_o   (seq_start),
        .mc_timeout_o (seq_timeout),
        .mc_stall_o   (seq_stall),
        .mc_active_o  (seq_active)
    );

    // Redirect and load-use are only meaningful when no multi-cycle op owns EX.
    always_comb begin
        ctrl = '0;
        if (rst_i) begin
            ctrl = '0;
        end else if (mem_stall) begin
            ctrl.stall_if  = 1'b1;
            ctrl.stall_id  = 1'b1;
            ctrl.stall_ex  = 1'b1;
            ctrl.stall_mem = 1'b1;
            ctrl.flush_wb  = 1'b1;
        end else if (seq_active) begin
            ctrl.stall_if  = seq_stall;
            ctrl.stall_id  = seq_stall;
            ctrl.stall_ex  = seq_stall;
            ctrl.flush_mem = seq_stall;
        end else if (ex_branch_taken_i) begin
            ctrl.flush_id = 1'b1;
            ctrl.flush_ex = 1'b1;
        end else if (load_use) begin
            ctrl.stall_if = 1'b1;
            ctrl.stall_id = 1'b1;
            ctrl.flush_ex = 1'b1;
        end
    end

    assign stall_if_o   = ctrl.stall_if;
    assign stall_id_o   = ctrl.stall_id;
    assign stall_ex_o   = ctrl.stall_ex;
    assign stall_mem_o  = ctrl.stall_mem;
    assign flush_id_o   = ctrl.flush_id;
    assign flush_ex_o   = ctrl.flush_ex;
    assign flush_mem_o  = ctrl.flush_mem;
    assign flush_wb_o   = ctrl.flush_wb;
    assign mc_start_o   = seq_start & ~rst_i;
    assign mc_timeout_o = seq_timeout & ~rst_i;

    assign stall_cnt_d = ctrl.stall_if ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: expected control vectors are queued as
// stimulus is driven and popped when the outputs are sampled before the next edge.
module tb_hazard_controller;

    localparam int CNT_W = 32;

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb, mc_start, mc_timeout}
    localparam logic [9:0] V_NONE = 10'b0000000000;
    localparam logic [9:0] V_LU   = 10'b1100010000;
    localparam logic [9:0] V_BR   = 10'b0000110000;
    localparam logic [9:0] V_MC   = 10'b1110001000;
    localparam logic [9:0] V_MCS  = 10'b1110001010;
    localparam logic [9:0] V_MEM  = 10'b1111000100;
    localparam logic [9:0] V_TMO  = 10'b0000000001;

    logic clk, rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read, ex_mc_op, ex_branch_taken;
    logic mc_done, mem_req, mem_ready;
    logic stall_if, stall_id, stall_ex, stall_mem;
    logic flush_id, flush_ex, flush_mem, flush_wb;
    logic mc_start, mc_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [9:0] exp_q[$];

    hazard_controller #(
        .MC_TIMEOUT (8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_uses_rs1_i     (id_uses_rs1),
        .id_uses_rs2_i     (id_uses_rs2),
        .ex_rd_i           (ex_rd),
        .ex_reg_write_i    (ex_reg_write),
        .ex_mem_read_i     (ex_mem_read),
        .ex_mc_op_i        (ex_mc_op),
        .ex_branch_taken_i (ex_branch_taken),
        .mc_done_i         (mc_done),
        .mem_req_i         (mem_req),
        .mem_ready_i       (mem_ready),
        .stall_if_o        (stall_if),
        .stall_id_o        (stall_id),
        .stall_ex_o        (stall_ex),
        .stall_mem_o       (stall_mem),
        .flush_id_o        (flush_id),
        .flush_ex_o        (flush_ex),
        .flush_mem_o       (flush_mem),
        .flush_wb_o        (flush_wb),
        .mc_start_o        (mc_start),
        .mc_timeout_o      (mc_timeout),
        .stall_cnt_o       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mc_op = 1'b0; ex_branch_taken = 1'b0;
        mc_done = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic load_in_ex(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic cyc(input string tag, input logic [9:0] exp_v);
        logic [9:0] got, want;
        exp_q.push_back(exp_v);
        if (rst) exp_cnt = '0;
        #2;
        got = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
               flush_mem, flush_wb, mc_start, mc_timeout};
        want = exp_q.pop_front();
        chk(tag, 32'(got), 32'(want));
        chk({tag, "_cnt"}, stall_cnt, exp_cnt);
        @(posedge clk);
        if (!rst && want[9]) exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        ex_mc_op = 1'b1; mem_req = 1'b1; load_in_ex(5'd3); id_uses_rs1 = 1'b1; id_rs1 = 5'd3;
        cyc("reset_quiet", V_NONE);
        rst = 1'b0;
        idle();
        cyc("idle", V_NONE);

        // load-use on rs1, then hazard gone
        load_in_ex(5'd5); id_uses_rs1 = 1'b1; id_rs1 = 5'd5;
        cyc("lu_rs1", V_LU);
        idle();
        cyc("lu_after", V_NONE);
        load_in_ex(5'd7); id_uses_rs2 = 1'b1; id_rs2 = 5'd7; id_rs1 = 5'd2; id_uses_rs1 = 1'b1;
        cyc("lu_rs2", V_LU);
        id_uses_rs2 = 1'b0;
        cyc("lu_rs2_unused", V_NONE);
        idle(); load_in_ex(5'd0); id_uses_rs1 = 1'b1; id_rs1 = 5'd0;
        cyc("lu_x0", V_NONE);
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_uses_rs1 = 1'b1; id_rs1 = 5'd9;
        cyc("lu_nowrite", V_NONE);

        // redirect masks load-use
        idle(); load_in_ex(5'd5); id_uses_rs1 = 1'b1; id_rs1 = 5'd5; ex_branch_taken = 1'b1;
        cyc("br_lu", V_BR);
        ex_branch_taken = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
        cyc("mem_over_lu", V_MEM);
        idle(); mem_req = 1'b1; mem_ready = 1'b1;
        cyc("mem_ready", V_NONE);

        // divide, done after 5 busy cycles; redirect ignored while busy
        idle(); ex_mc_op = 1'b1;
        cyc("div_start", V_MCS);
        for (int i = 1; i <= 5; i++) begin
            ex_branch_taken = (i == 3);
            cyc($sformatf("div_busy%0d", i), V_MC);
        end
        ex_branch_taken = 1'b0; mc_done = 1'b1;
        cyc("div_done", V_NONE);
        idle();
        cyc("div_after", V_NONE);

        // timeout at 8th cycle, then RUN accepts a new op
        ex_mc_op = 1'b1;
        cyc("tmo_start", V_MCS);
        for (int i = 1; i <= 6; i++) cyc($sformatf("tmo_busy%0d", i), V_MC);
        cyc("tmo_pulse", V_TMO);
        idle();
        cyc("tmo_after", V_NONE);
        ex_mc_op = 1'b1;
        cyc("tmo_restart", V_MCS);
        mc_done = 1'b1;
        cyc("tmo_restart_done", V_NONE);
        idle();

        // dmem wait inside MC_BUSY
        ex_mc_op = 1'b1;
        cyc("mw_start", V_MCS);
        cyc("mw_busy1", V_MC);
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("mw_wait%0d", i), V_MEM);
        mem_req = 1'b0;
        cyc("mw_busy2", V_MC);
        mc_done = 1'b1;
        cyc("mw_done", V_NONE);
        idle();

        // async reset mid MC_BUSY
        ex_mc_op = 1'b1;
        cyc("ar_start", V_MCS);
        cyc("ar_busy1", V_MC);
        cyc("ar_busy2", V_MC);
        rst = 1'b1;
        cyc("ar_reset", V_NONE);
        rst = 1'b0; ex_mc_op = 1'b0;
        cyc("ar_release", V_NONE);
        ex_mc_op = 1'b1;
        cyc("ar_restart", V_MCS);
        mc_done = 1'b1;
        cyc("ar_done", V_NONE);
        idle();
        cyc("final", V_NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
